// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
//   MODE_EDGE / MODE_CENTRE : counting modes selected by the mode input
//   dir_t                   : up/down direction of the shared period counter
//   is_centre()             : true when the counter really runs up/down
//                             (centre mode with a non-zero period)
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTRE = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // A zero period in centre mode cannot reverse, so it is treated as edge mode.
    function automatic logic is_centre(input logic mode_bit, input logic period_nonzero);
        is_centre = (mode_bit == MODE_CENTRE) && period_nonzero;
    endfunction

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: double-buffered duty plus the registered comparator.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            run enable; forces the output low when 0
//   cnt           shared period counter value
//   duty_in       duty value for this channel
//   load_pending  capture duty_in into the pending buffer
//   load_active   copy the pending buffer into the active duty
//   pwm           registered PWM output (cnt < active duty)
module pwm_channel_cmp
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             load_pending,
    input  logic             load_active,
    output logic             pwm
);

    logic [WIDTH-1:0] duty_pend_r;
    logic [WIDTH-1:0] duty_act_r;
    logic             pwm_r;

    // Pending duty buffer, written by the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_pend_r <= {WIDTH{1'b0}};
        end else if (load_pending) begin
            duty_pend_r <= duty_in;
        end
    end

    // Active duty, only changed at a period boundary or while stopped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_act_r <= {WIDTH{1'b0}};
        end else if (load_active) begin
            duty_act_r <= duty_pend_r;
        end
    end

    // Output flop: uses the duty that was active for this counter value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r <= 1'b0;
        end else begin
            pwm_r <= en & (cnt < duty_act_r);
        end
    end

    assign pwm = pwm_r;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with a shared prescaled period counter.
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   en          run enable
//   mode        0 = edge-aligned, 1 = centre-aligned
//   prescale    counter advances every prescale+1 clocks
//   period      counter top value
//   duty_in     channel i duty at [i*WIDTH +: WIDTH]
//   duty_valid  duty write request
//   duty_ready  pending duty buffer is free
//   pwm_out     registered PWM outputs
//   period_end  one-clock pulse at each period boundary
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic [PRESC_W-1:0]        prescale,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      duty_valid,
    output logic                      duty_ready,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_end
);

    localparam logic [WIDTH-1:0]   CNT_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   CNT_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   CNT_ONES   = {WIDTH{1'b1}};
    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] presc_cnt_r;
    logic [PRESC_W-1:0] presc_nxt_s;
    logic               tick_s;

    logic [WIDTH-1:0]   cnt_r;
    logic [WIDTH-1:0]   cnt_nxt_s;
    dir_t               dir_r;
    dir_t               dir_nxt_s;
    logic               boundary_s;

    logic [WIDTH-1:0]   period_act_r;
    logic               mode_act_r;
    logic               centre_act_s;
    logic               centre_new_s;

    logic               pending_r;
    logic               accept_s;
    logic               load_active_s;
    logic               period_end_r;

    assign centre_act_s = is_centre(mode_act_r, period_act_r != CNT_ZERO);
    // Configuration that becomes active at this boundary decides how the
    // counter restarts: a centre-to-centre boundary continues upward at 1.
    assign centre_new_s = is_centre(mode, period != CNT_ZERO);

    // Prescaler: tick when the count matches the live prescale value
    always_comb begin
        tick_s      = 1'b0;
        presc_nxt_s = presc_cnt_r;
        if (!en) begin
            presc_nxt_s = PRESC_ZERO;
        end else if (presc_cnt_r == prescale) begin
            tick_s      = 1'b1;
            presc_nxt_s = PRESC_ZERO;
        end else begin
            presc_nxt_s = presc_cnt_r + PRESC_ONE;
        end
    end

    // Prescaler count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_r <= PRESC_ZERO;
        end else begin
            presc_cnt_r <= presc_nxt_s;
        end
    end

    // Counter/direction next state and boundary detection
    always_comb begin
        cnt_nxt_s  = cnt_r;
        dir_nxt_s  = dir_r;
        boundary_s = 1'b0;
        if (!en) begin
            cnt_nxt_s = CNT_ZERO;
            dir_nxt_s = DIR_UP;
        end else if (!tick_s) begin
            cnt_nxt_s = cnt_r;
        end else if (!centre_act_s) begin
            dir_nxt_s = DIR_UP;
            if (cnt_r == period_act_r) begin
                boundary_s = 1'b1;
                cnt_nxt_s  = CNT_ZERO;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else begin
            case (dir_r)
                DIR_UP: begin
                    if (cnt_r >= period_act_r) begin
                        dir_nxt_s = DIR_DOWN;
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                DIR_DOWN: begin
                    if (cnt_r == CNT_ZERO) begin
                        boundary_s = 1'b1;
                        dir_nxt_s  = DIR_UP;
                        cnt_nxt_s  = centre_new_s ? CNT_ONE : CNT_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    dir_nxt_s = DIR_UP;
                    cnt_nxt_s = CNT_ZERO;
                end
            endcase
        end
    end

    // Counter and direction state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
            dir_r <= DIR_UP;
        end else begin
            cnt_r <= cnt_nxt_s;
            dir_r <= dir_nxt_s;
        end
    end

    // Active period/mode: tracked while stopped, sampled at each boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_act_r <= CNT_ONES;
            mode_act_r   <= MODE_EDGE;
        end else if (!en || boundary_s) begin
            period_act_r <= period;
            mode_act_r   <= mode;
        end
    end

    // Accept only into a free buffer; a held write lands the clock after the
    // boundary that frees it. The two events are exclusive by construction.
    assign accept_s      = duty_valid & ~pending_r;
    assign load_active_s = pending_r & (~en | boundary_s);

    // Pending flag for the double-buffered duty handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 1'b0;
        end else if (accept_s) begin
            pending_r <= 1'b1;
        end else if (load_active_s) begin
            pending_r <= 1'b0;
        end
    end

    // Period boundary pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_end_r <= 1'b0;
        end else begin
            period_end_r <= boundary_s;
        end
    end

    assign duty_ready = ~pending_r;
    assign period_end = period_end_r;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_channel_cmp #(
            .WIDTH(WIDTH)
        ) u_cmp (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (en),
            .cnt         (cnt_r),
            .duty_in     (duty_in[g*WIDTH +: WIDTH]),
            .load_pending(accept_s),
            .load_active (load_active_s),
            .pwm         (pwm_out[g])
        );
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel: a behavioural model queues the
// expected outputs each clock, a monitor pops and compares on the falling edge.
module tb_pwm_multi_channel;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int PRESC_W  = 8;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      en;
    logic                      mode;
    logic [PRESC_W-1:0]        prescale;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] duty_in;
    logic                      duty_valid;
    logic                      duty_ready;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_end;

    int n_checks = 0;
    int n_pass   = 0;

    logic [CHANNELS*WIDTH-1:0] duty_word;

    always #5 clk = ~clk;

    pwm_multi_channel #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .prescale  (prescale),
        .period    (period),
        .duty_in   (duty_in),
        .duty_valid(duty_valid),
        .duty_ready(duty_ready),
        .pwm_out   (pwm_out),
        .period_end(period_end)
    );

    typedef struct packed {
        logic [CHANNELS-1:0] pwm;
        logic                pe;
        logic                rdy;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model. Position within a period is a phase index; the counter
    // value is the phase (edge) or a triangle of it (centre).
    int   m_presc, m_phase, m_period, m_cv;
    logic m_mode, m_pend, m_cl, m_cl_new, m_tick, m_bnd, m_acc;
    int   m_pend_duty[CHANNELS];
    int   m_act_duty[CHANNELS];
    exp_t m_e;

    function automatic int tri_value(input int phase, input int p, input logic centre);
        if (centre && phase > p) return 2 * p - phase;
        return phase;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_presc = 0; m_phase = 0; m_period = 255; m_mode = 1'b0; m_pend = 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                m_pend_duty[i] = 0;
                m_act_duty[i]  = 0;
            end
            exp_q.delete();
        end else begin
            m_cl   = m_mode && (m_period != 0);
            m_cv   = tri_value(m_phase, m_period, m_cl);
            for (int i = 0; i < CHANNELS; i++) m_e.pwm[i] = en && (m_cv < m_act_duty[i]);
            m_tick = en && (m_presc == int'(prescale));
            m_bnd  = m_tick && (m_cl ? (m_phase == 2 * m_period) : (m_phase == m_period));
            m_e.pe = m_bnd;
            m_acc  = duty_valid && !m_pend;
            if (!en) begin
                m_presc = 0; m_phase = 0;
                m_period = int'(period); m_mode = mode;
                if (m_pend) begin
                    for (int i = 0; i < CHANNELS; i++) m_act_duty[i] = m_pend_duty[i];
                    m_pend = 1'b0;
                end
            end else if (m_tick) begin
                m_presc = 0;
                if (m_bnd) begin
                    m_cl_new = mode && (period != 8'd0);
                    m_phase  = (m_cl && m_cl_new) ? 1 : 0;
                    m_period = int'(period); m_mode = mode;
                    if (m_pend) begin
                        for (int i = 0; i < CHANNELS; i++) m_act_duty[i] = m_pend_duty[i];
                        m_pend = 1'b0;
                    end
                end else begin
                    m_phase++;
                end
            end else begin
                m_presc = (m_presc + 1) % 256;
            end
            if (m_acc) begin
                m_pend = 1'b1;
                for (int i = 0; i < CHANNELS; i++) m_pend_duty[i] = int'(duty_in[i*WIDTH +: WIDTH]);
            end
            m_e.rdy = !m_pend;
            exp_q.push_back(m_e);
        end
    end

    // Monitor: compares one queued expectation per clock
    exp_t mon_e;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_pwm", 32'(pwm_out), 32'd0);
            chk("rst_pe", 32'(period_end), 32'd0);
            chk("rst_ready", 32'(duty_ready), 32'd1);
        end else if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_pwm", 32'(pwm_out), 32'(mon_e.pwm));
            chk("sb_period_end", 32'(period_end), 32'(mon_e.pe));
            chk("sb_duty_ready", 32'(duty_ready), 32'(mon_e.rdy));
        end
    end

    task automatic drive_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_duty(input string name, input logic [CHANNELS*WIDTH-1:0] d);
        logic was;
        int   budget;
        was = 1'b0;
        budget = 0;
        duty_in = d;
        duty_valid = 1'b1;
        while (budget < 200) begin
            was = duty_ready;
            drive_cyc(1);
            budget++;
            if (was) break;
        end
        duty_valid = 1'b0;
        chk(name, 32'(was), 32'd1);
    endtask

    task automatic set_ch0(input string name, input logic [7:0] d);
        duty_word[7:0] = d;
        write_duty(name, duty_word);
    endtask

    task automatic wait_pe();
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!period_end && budget < 1000);
        chk("pe_seen", 32'(period_end), 32'd1);
    endtask

    task automatic measure(input int n, output int hi, output int pe);
        hi = 0;
        pe = 0;
        repeat (n) begin
            @(negedge clk);
            hi += int'(pwm_out[0]);
            pe += int'(period_end);
        end
    endtask

    task automatic gap(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_end && n < 1000);
    endtask

    int hi, pe, g;
    int budget;

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; prescale = 8'd0; period = 8'd9;
        duty_in = '0; duty_valid = 1'b0;
        duty_word = {8'd12, 8'd5, 8'd0, 8'd3};
        drive_cyc(3);
        rst_n = 1'b1;
        drive_cyc(1);

        // 1: edge, P=9, ch0 duty 3
        write_duty("t1_write", duty_word);
        drive_cyc(2);
        en = 1'b1;
        wait_pe();
        measure(10, hi, pe);
        chk("t1_high", 32'(hi), 32'd3);
        chk("t1_pe", 32'(pe), 32'd1);

        // 2: centre, P=4, ch0 duty 2
        mode = 1'b1; period = 8'd4;
        set_ch0("t2_write", 8'd2);
        wait_pe();
        wait_pe();
        measure(8, hi, pe);
        chk("t2_pe", 32'(pe), 32'd1);

        // 3: mid-period write, then a held second write
        mode = 1'b0; period = 8'd9;
        set_ch0("t3_write0", 8'd3);
        wait_pe();
        wait_pe();
        drive_cyc(3);
        set_ch0("t3_write1", 8'd5);
        chk("t3_ready_low", 32'(duty_ready), 32'd0);
        set_ch0("t3_write2", 8'd7);
        chk("t3_ready_low2", 32'(duty_ready), 32'd0);
        wait_pe();
        measure(10, hi, pe);
        chk("t3_high7", 32'(hi), 32'd7);

        // 4: duty limits and prescaler
        set_ch0("t4_write0", 8'd0);
        wait_pe(); wait_pe();
        measure(10, hi, pe);
        chk("t4_duty0", 32'(hi), 32'd0);
        set_ch0("t4_write10", 8'd10);
        wait_pe(); wait_pe();
        measure(20, hi, pe);
        chk("t4_duty10", 32'(hi), 32'd20);
        prescale = 8'd2;
        set_ch0("t4_write3", 8'd3);
        wait_pe(); wait_pe();
        measure(30, hi, pe);
        chk("t4_presc_high", 32'(hi), 32'd9);
        chk("t4_presc_pe", 32'(pe), 32'd1);
        en = 1'b0; prescale = 8'd0;
        drive_cyc(2);
        en = 1'b1;

        // 5: period change mid-period
        wait_pe();
        drive_cyc(1);
        period = 8'd4;
        gap(g);
        chk("t5_gap_old", 32'(g), 32'd10);
        gap(g);
        chk("t5_gap_new", 32'(g), 32'd5);

        // 6: asynchronous reset mid-period, then restart
        set_ch0("t6_write", 8'd3);
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!pwm_out[0] && budget < 50);
        chk("t6_pre_pwm", 32'(pwm_out[0]), 32'd1);
        chk("t6_pre_ready", 32'(duty_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_pwm", 32'(pwm_out), 32'd0);
        chk("t6_async_ready", 32'(duty_ready), 32'd1);
        en = 1'b0;
        drive_cyc(2);
        rst_n = 1'b1;
        set_ch0("t6_write_new", 8'd2);
        drive_cyc(2);
        en = 1'b1;
        measure(5, hi, pe);
        chk("t6_start_high", 32'(hi), 32'd2);
        chk("t6_start_pe", 32'(pe), 32'd0);
        drive_cyc(1);

        // Randomised traffic against the model
        for (int c = 0; c < 8; c++) begin
            en = 1'b0;
            prescale = 8'($urandom_range(0, 2));
            mode = 1'($urandom_range(0, 1));
            period = 8'($urandom_range(0, 12));
            drive_cyc(2);
            en = 1'b1;
            for (int k = 0; k < 300; k++) begin
                duty_valid = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < CHANNELS; i++) duty_in[i*WIDTH +: WIDTH] = 8'($urandom_range(0, 14));
                if ($urandom_range(0, 39) == 0) begin
                    mode = 1'($urandom_range(0, 1));
                    period = 8'($urandom_range(0, 12));
                end
                if ($urandom_range(0, 149) == 0) en = ~en;
                drive_cyc(1);
            end
            duty_valid = 1'b0;
        end
        drive_cyc(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
